// File: rtl/poly_mul_host_seq.sv
// Host sequencer for the schoolbook multiplier wrapper: streams A/B into the
// wrapper memory, pulses start, waits for done, then streams C back out.
module poly_mul_host_seq #(
    parameter int N_COEF  = 64,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mul_start,
    input  logic              mul_done,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

    localparam int                LAST     = 2 * N_COEF - 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST);
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ld_idx_q, ld_idx_d;
    logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                rd_done_q, rd_done_d;
    logic                timeout_err_q, timeout_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ld_idx_q      <= '0;
            rd_idx_q      <= '0;
            wait_cnt_q    <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_idx_q      <= ld_idx_d;
            rd_idx_q      <= rd_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            rd_done_q     <= rd_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ld_idx_d      = ld_idx_q;
        rd_idx_d      = rd_idx_q;
        wait_cnt_d    = wait_cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        rd_done_d     = rd_done_q;
        timeout_err_d = timeout_err_q;
        in_ready      = 1'b0;
        mem_we        = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        mul_start     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) state_d = LOAD;
            end
            LOAD: begin
                in_ready    = 1'b1;
                mem_we      = in_valid;
                mem_address = ld_idx_q;
                mem_wdata   = in_data;
                if (in_valid) begin
                    timeout_err_d = 1'b0;
                    if (ld_idx_q == LAST_IDX) begin
                        ld_idx_d = '0;
                        state_d  = START;
                    end else begin
                        ld_idx_d = ld_idx_q + ADDR_W'(1);
                    end
                end
            end
            START: begin
                mul_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    state_d = UNLOAD;
                end else if (TIMEOUT != 0 && wait_cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            UNLOAD: begin
                mem_address = rd_idx_q;
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
                // rd_done_q stops capture once C[LAST] is held, since rd_idx cannot pass LAST
                if (!rd_done_q && (!out_valid_q || out_ready)) begin
                    out_data_d  = mem_rdata;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_idx_q == LAST_IDX);
                    if (rd_idx_q == LAST_IDX) rd_done_d = 1'b1;
                    else                      rd_idx_d  = rd_idx_q + ADDR_W'(1);
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rd_done_d   = 1'b0;
                    rd_idx_d    = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_poly_mul_host_seq.sv
// Directed bench for poly_mul_host_seq with a behavioural wrapper model and a
// schoolbook reference product checked on every output handshake.
module tb_poly_mul_host_seq;

    localparam int NW       = 128;
    localparam int TO       = 16;
    localparam int DONE_LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [6:0]  mem_address;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mul_start;
    logic        mul_done;
    logic        busy;
    logic        timeout_err;

    poly_mul_host_seq #(.N_COEF(64), .DATA_W(16), .ADDR_W(7), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .mul_start(mul_start), .mul_done(mul_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [15:0] coef [NW];
    logic [15:0] expv [NW];
    logic [15:0] got_w [NW];
    logic [15:0] wmem [NW];
    logic [15:0] cmem [NW];

    bit done_en  = 1'b1;
    bit rdy_mode = 1'b0;

    int wr_cnt = 0, out_cnt = 0, starts = 0, start_cyc = -100, done_cyc = -100;
    int jobs_ended = 0, last_job_outs = -1, last_job_wrs = -1, first_wr_cyc = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {busy, in_ready, out_valid, out_last, mem_we, mul_start, timeout_err,
                   out_data, mem_address, mem_wdata}, '0);
    endtask

    // Wrapper model: write stores operand and clears C[addr]; start accumulates A*B.
    assign mem_rdata = cmem[mem_address];
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                wmem[mem_address] = mem_wdata;
                cmem[mem_address] = '0;
            end
            if (mul_start)
                for (int i = 0; i < 64; i++)
                    for (int j = 0; j < 64; j++)
                        cmem[i+j] = cmem[i+j] + 16'(wmem[i] * wmem[64+j]);
        end
    end

    initial begin
        mul_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            mul_done = done_en && (cyc == start_cyc + DONE_LAT);
            if (mul_done) done_cyc = cyc;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        end
    end

    // Per-cycle compare process.
    initial begin
        bit          prev_busy = 0, prev_start = 0, prev_stall = 0, first_seen = 0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wr_cnt = 0; out_cnt = 0;
                prev_busy = 0; prev_start = 0; prev_stall = 0; first_seen = 0;
            end else begin
                chk("we_is_handshake", mem_we, in_valid & in_ready);
                if (!busy) chk("idle_quiet", {in_ready, mem_we, mul_start, out_valid}, '0);
                if (mem_we) begin
                    if (wr_cnt == 0) first_wr_cyc = cyc;
                    if (wr_cnt < NW) begin
                        chk("wr_addr", mem_address, wr_cnt);
                        chk("wr_data", mem_wdata, coef[wr_cnt]);
                    end else fail("wr_overflow");
                    wr_cnt++;
                end
                if (mul_start) begin
                    chk("start_after_load", wr_cnt, NW);
                    chk("start_pulse_width", prev_start, 0);
                    starts++;
                    start_cyc = cyc;
                end
                prev_start = mul_start;
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", out_last, prev_last);
                end
                if (out_valid && !first_seen) begin
                    chk("first_out_latency", cyc, done_cyc + 2);
                    first_seen = 1;
                end
                if (out_valid && out_ready) begin
                    if (out_cnt < NW) begin
                        chk("out_data", out_data, expv[out_cnt]);
                        chk("out_last", out_last, out_cnt == NW - 1);
                        got_w[out_cnt] = out_data;
                    end else fail("out_overflow");
                    out_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (prev_busy && !busy) begin
                    last_job_outs = out_cnt;
                    last_job_wrs  = wr_cnt;
                    jobs_ended++;
                    wr_cnt = 0; out_cnt = 0; first_seen = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic calc_exp();
        for (int k = 0; k < NW; k++) expv[k] = '0;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++)
                expv[i+j] = expv[i+j] + 16'(coef[i] * coef[64+j]);
    endtask

    task automatic set_t1();
        for (int k = 0; k < 64; k++) begin
            coef[k]    = (k == 0) ? 16'd1 : 16'd0;
            coef[64+k] = 16'(k + 1);
        end
        calc_exp();
    endtask

    task automatic set_rand();
        for (int k = 0; k < NW; k++) coef[k] = 16'($urandom);
        calc_exp();
    endtask

    task automatic load_job(input bit toggle, input int stop_at);
        int idx = 0;
        int guard = 0;
        bit v = 1'b0;
        while (idx < stop_at && guard < 2000) begin
            @(posedge clk); #1;
            v = toggle ? ~v : 1'b1;
            in_valid = v;
            in_data  = coef[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        if (idx < stop_at) fail("load_progress");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_final();
        int guard = 0;
        bit hit = 0;
        while (!hit && guard < 2000) begin
            @(negedge clk); #1;
            hit = out_valid && out_ready && out_last;
            guard++;
        end
        if (!hit) fail("wait_final");
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk_zero("reset_outputs_immediate");
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs_held");
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset_outputs_after");
    endtask

    initial begin
        int s0;
        int fcyc;
        int guard;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("post_reset_state");

        // 1: A = 1,0..0 ; B = k+1 -> C = 1..64 then zeros
        set_t1();
        s0 = starts;
        load_job(1'b0, NW);
        wait_final();
        settle();
        chk("t1_words", last_job_outs, NW);
        chk("t1_writes", last_job_wrs, NW);
        chk("t1_starts", starts - s0, 1);
        chk("t1_c0", got_w[0], 16'd1);
        chk("t1_c63", got_w[63], 16'd64);
        chk("t1_c64", got_w[64], 16'd0);
        chk("t1_c127", got_w[127], 16'd0);

        // 2: same job, in_valid toggling
        set_t1();
        load_job(1'b1, NW);
        wait_final();
        settle();
        chk("t2_words", last_job_outs, NW);
        chk("t2_writes", last_job_wrs, NW);
        chk("t2_c10", got_w[10], 16'd11);

        // 3: out_ready 1,0,0,1 ; A = k+1, B = 1,1,0.. -> C[k] = A[k] + A[k-1]
        for (int k = 0; k < 64; k++) begin
            coef[k]    = 16'(k + 1);
            coef[64+k] = (k < 2) ? 16'd1 : 16'd0;
        end
        calc_exp();
        rdy_mode = 1'b1;
        load_job(1'b0, NW);
        wait_final();
        settle();
        rdy_mode = 1'b0;
        chk("t3_words", last_job_outs, NW);
        chk("t3_c1", got_w[1], 16'd3);
        chk("t3_c63", got_w[63], 16'd127);
        chk("t3_c64", got_w[64], 16'd64);

        // 4: done never arrives -> timeout 16 cycles after WAIT entry
        done_en = 1'b0;
        set_t1();
        s0 = starts;
        load_job(1'b0, NW);
        guard = 0;
        while (starts == s0 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (starts == s0) fail("t4_start_seen");
        while (cyc < start_cyc + TO) @(negedge clk);
        chk("t4_err_before", timeout_err, 0);
        chk("t4_busy_before", busy, 1);
        @(negedge clk);
        chk("t4_err_at", timeout_err, 1);
        chk("t4_busy_at", busy, 0);
        chk("t4_no_out", out_valid, 0);
        settle();
        chk("t4_words", last_job_outs, 0);
        chk("t4_err_sticky", timeout_err, 1);
        done_en = 1'b1;
        set_rand();
        load_job(1'b0, NW);
        wait_final();
        settle();
        chk("t4_err_cleared", timeout_err, 0);
        chk("t4_next_words", last_job_outs, NW);

        // 5: reset mid-load, then mid-unload, each followed by a fresh job
        set_rand();
        load_job(1'b0, 40);
        reset_pulse();
        set_rand();
        load_job(1'b0, NW);
        wait_final();
        settle();
        chk("t5a_words", last_job_outs, NW);
        set_rand();
        load_job(1'b0, NW);
        guard = 0;
        while (out_cnt < 70 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (out_cnt < 70) fail("t5_reach_unload");
        reset_pulse();
        set_rand();
        load_job(1'b0, NW);
        wait_final();
        settle();
        chk("t5b_words", last_job_outs, NW);

        // 6: back-to-back random jobs
        set_rand();
        load_job(1'b0, NW);
        wait_final();
        fcyc = cyc;
        set_rand();
        load_job(1'b0, NW);
        chk("t6_b2b_gap", first_wr_cyc, fcyc + 2);
        wait_final();
        settle();
        chk("t6_words", last_job_outs, NW);
        chk("t6_writes", last_job_wrs, NW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
